// File: rtl/port_ram_dp.sv
// port_ram_dp: dual-port scratch RAM with byte-enabled read/write port A,
// read-only port B, 1-cycle registered read data and a clear engine that
// zeroes the whole array after reset or on a clr pulse.
module port_ram_dp #(
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int RDW_MODE = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   output logic                  busy,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic                  a_we,
   input  logic [ADDR_W-1:0]     a_addr,
   input  logic [DATA_W-1:0]     a_wdata,
   input  logic [DATA_W/8-1:0]   a_be,
   output logic                  a_rvalid,
   output logic [DATA_W-1:0]     a_rdata,
   output logic                  a_err,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [ADDR_W-1:0]     b_addr,
   output logic                  b_rvalid,
   output logic [DATA_W-1:0]     b_rdata,
   output logic                  b_err
);

   localparam int                NB        = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

   state_t              state_r;
   logic [ADDR_W-1:0]   clr_addr_r;
   logic                busy_r;
   logic                a_ready_r;
   logic                b_ready_r;
   logic                a_rvalid_r;
   logic                b_rvalid_r;
   logic                a_err_r;
   logic                b_err_r;
   logic [DATA_W-1:0]   a_rdata_r;
   logic [DATA_W-1:0]   b_rdata_r;
   logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

   logic                a_acc_s;
   logic                a_wr_s;
   logic                a_rd_s;
   logic                b_rd_s;
   logic                a_in_rng_s;
   logic                b_in_rng_s;
   logic [DATA_W-1:0]   a_word_s;
   logic [DATA_W-1:0]   b_word_s;

   // Replace the enabled bytes of old_w with those of new_w.
   function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [NB-1:0]     be);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end
      end
      return res;
   endfunction

   assign a_acc_s    = a_valid & a_ready_r;
   assign a_wr_s     = a_acc_s & a_we;
   assign a_rd_s     = a_acc_s & ~a_we;
   assign b_rd_s     = b_valid & b_ready_r;
   assign a_in_rng_s = ({1'b0, a_addr} < DEPTH_L);
   assign b_in_rng_s = ({1'b0, b_addr} < DEPTH_L);

   // Read words for both ports; out-of-range reads return zero, B may forward A's write.
   always_comb begin
      a_word_s = '0;
      b_word_s = '0;
      if (a_in_rng_s) begin
         a_word_s = mem_r[a_addr];
      end else begin
         a_word_s = '0;
      end
      if (!b_in_rng_s) begin
         b_word_s = '0;
      end else if ((RDW_MODE != 0) && a_wr_s && a_in_rng_s && (a_addr == b_addr)) begin
         b_word_s = merge_be(mem_r[b_addr], a_wdata, a_be);
      end else begin
         b_word_s = mem_r[b_addr];
      end
   end

   // Array storage: clear engine writes zeros, otherwise port A byte-enabled writes.
   always_ff @(posedge clk) begin
      if (rst_n && (state_r == ST_CLEAR)) begin
         mem_r[clr_addr_r] <= '0;
      end else if (rst_n && a_wr_s && a_in_rng_s) begin
         for (int i = 0; i < NB; i++) begin
            if (a_be[i]) begin
               mem_r[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            end
         end
      end
   end

   // CLEAR/RUN state machine with registered handshake and read responses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_CLEAR;
         clr_addr_r <= '0;
         busy_r     <= 1'b1;
         a_ready_r  <= 1'b0;
         b_ready_r  <= 1'b0;
         a_rvalid_r <= 1'b0;
         b_rvalid_r <= 1'b0;
         a_err_r    <= 1'b0;
         b_err_r    <= 1'b0;
         a_rdata_r  <= '0;
         b_rdata_r  <= '0;
      end else begin
         case (state_r)
            ST_CLEAR: begin
               if (clr_addr_r == LAST_ADDR) begin
                  state_r    <= ST_RUN;
                  clr_addr_r <= '0;
                  busy_r     <= 1'b0;
                  a_ready_r  <= 1'b1;
                  b_ready_r  <= 1'b1;
               end else begin
                  clr_addr_r <= clr_addr_r + 1'b1;
               end
            end
            ST_RUN: begin
               if (clr) begin
                  state_r    <= ST_CLEAR;
                  clr_addr_r <= '0;
                  busy_r     <= 1'b1;
                  a_ready_r  <= 1'b0;
                  b_ready_r  <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_CLEAR;
               clr_addr_r <= '0;
               busy_r     <= 1'b1;
               a_ready_r  <= 1'b0;
               b_ready_r  <= 1'b0;
            end
         endcase
         a_rvalid_r <= a_rd_s;
         b_rvalid_r <= b_rd_s;
         a_err_r    <= a_acc_s & ~a_in_rng_s;
         b_err_r    <= b_rd_s & ~b_in_rng_s;
         if (a_rd_s) begin
            a_rdata_r <= a_word_s;
         end
         if (b_rd_s) begin
            b_rdata_r <= b_word_s;
         end
      end
   end

   assign busy     = busy_r;
   assign a_ready  = a_ready_r;
   assign b_ready  = b_ready_r;
   assign a_rvalid = a_rvalid_r;
   assign a_rdata  = a_rdata_r;
   assign a_err    = a_err_r;
   assign b_rvalid = b_rvalid_r;
   assign b_rdata  = b_rdata_r;
   assign b_err    = b_err_r;

endmodule

// File: tb/tb_port_ram_dp.sv
// tb_port_ram_dp: directed bench for port_ram_dp. Three instances share the
// stimulus: default build (old-data RDW), forwarding build, and DEPTH=200.
module tb_port_ram_dp;

   logic        clk = 1'b0;
   logic        rst_n, clr;
   logic        a_valid, a_we, b_valid;
   logic [7:0]  a_addr, b_addr;
   logic [15:0] a_wdata;
   logic [1:0]  a_be;

   logic        busy0, a_ready0, a_rvalid0, a_err0, b_ready0, b_rvalid0, b_err0;
   logic [15:0] a_rdata0, b_rdata0;
   logic        busy1, a_ready1, a_rvalid1, a_err1, b_ready1, b_rvalid1, b_err1;
   logic [15:0] a_rdata1, b_rdata1;
   logic        busy2, a_ready2, a_rvalid2, a_err2, b_ready2, b_rvalid2, b_err2;
   logic [15:0] a_rdata2, b_rdata2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   port_ram_dp #(.DATA_W(16), .DEPTH(256), .RDW_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy0),
      .a_valid(a_valid), .a_ready(a_ready0), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_be(a_be), .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
      .a_err(a_err0), .b_valid(b_valid), .b_ready(b_ready0), .b_addr(b_addr),
      .b_rvalid(b_rvalid0), .b_rdata(b_rdata0), .b_err(b_err0));

   port_ram_dp #(.DATA_W(16), .DEPTH(256), .RDW_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy1),
      .a_valid(a_valid), .a_ready(a_ready1), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_be(a_be), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
      .a_err(a_err1), .b_valid(b_valid), .b_ready(b_ready1), .b_addr(b_addr),
      .b_rvalid(b_rvalid1), .b_rdata(b_rdata1), .b_err(b_err1));

   port_ram_dp #(.DATA_W(16), .DEPTH(200), .RDW_MODE(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy2),
      .a_valid(a_valid), .a_ready(a_ready2), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_be(a_be), .a_rvalid(a_rvalid2), .a_rdata(a_rdata2),
      .a_err(a_err2), .b_valid(b_valid), .b_ready(b_ready2), .b_addr(b_addr),
      .b_rvalid(b_rvalid2), .b_rdata(b_rdata2), .b_err(b_err2));

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [7:0] addr, input logic [15:0] data, input logic [1:0] be);
      a_valid = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data; a_be = be;
      step();
      a_valid = 1'b0; a_we = 1'b0;
   endtask

   task automatic a_read(input logic [7:0] addr);
      a_valid = 1'b1; a_we = 1'b0; a_addr = addr;
      step();
      a_valid = 1'b0;
   endtask

   // Count cycles until dut0 leaves clear; also records when dut2 leaves clear.
   task automatic count_busy(output int n0, output int n2);
      n0 = 0; n2 = 0;
      for (int i = 0; i < 400; i++) begin
         step();
         n0++;
         if (!busy2 && n2 == 0) n2 = n0;
         if (!busy0) break;
      end
   endtask

   task automatic test_reset();
      int n0, n2;
      rst_n = 1'b0;
      step(); step();
      tests++; if (busy0 !== 1'b1 || a_ready0 !== 1'b0 || b_ready0 !== 1'b0) begin fails++; $display("FAIL reset_hs busy=%b a_ready=%b b_ready=%b exp 1 0 0", busy0, a_ready0, b_ready0); end
      tests++; if (a_rvalid0 !== 1'b0 || a_rdata0 !== 16'h0000 || b_rvalid0 !== 1'b0) begin fails++; $display("FAIL reset_resp a_rvalid=%b a_rdata=%h b_rvalid=%b exp 0 0000 0", a_rvalid0, a_rdata0, b_rvalid0); end
      rst_n = 1'b1;
      count_busy(n0, n2);
      tests++; if (n0 !== 256) begin fails++; $display("FAIL clear_len256 got %0d exp 256", n0); end
      tests++; if (n2 !== 200) begin fails++; $display("FAIL clear_len200 got %0d exp 200", n2); end
      tests++; if (a_ready0 !== 1'b1 || b_ready0 !== 1'b1) begin fails++; $display("FAIL ready_after_clear got %b%b exp 11", a_ready0, b_ready0); end
      a_read(8'd0);
      tests++; if (a_rvalid0 !== 1'b1 || a_rdata0 !== 16'h0000) begin fails++; $display("FAIL rd0 rvalid=%b data=%h exp 1 0000", a_rvalid0, a_rdata0); end
      step();
      tests++; if (a_rvalid0 !== 1'b0) begin fails++; $display("FAIL rvalid_one_cycle got %b exp 0", a_rvalid0); end
      a_read(8'd128);
      tests++; if (a_rvalid0 !== 1'b1 || a_rdata0 !== 16'h0000) begin fails++; $display("FAIL rd128 rvalid=%b data=%h exp 1 0000", a_rvalid0, a_rdata0); end
      a_read(8'd255);
      tests++; if (a_rvalid0 !== 1'b1 || a_rdata0 !== 16'h0000 || a_err0 !== 1'b0) begin fails++; $display("FAIL rd255 rvalid=%b data=%h err=%b exp 1 0000 0", a_rvalid0, a_rdata0, a_err0); end
   endtask

   task automatic test_byte_enable();
      a_write(8'd5, 16'hBEEF, 2'b11);
      a_write(8'd5, 16'h1234, 2'b10);
      a_read(8'd5);
      tests++; if (a_rdata0 !== 16'h12EF || a_rvalid0 !== 1'b1) begin fails++; $display("FAIL be_hi got %h exp 12ef", a_rdata0); end
      tests++; if (a_rdata2 !== 16'h12EF) begin fails++; $display("FAIL be_hi_d200 got %h exp 12ef", a_rdata2); end
      a_write(8'd5, 16'hFFFF, 2'b00);
      a_read(8'd5);
      tests++; if (a_rdata0 !== 16'h12EF) begin fails++; $display("FAIL be_none got %h exp 12ef", a_rdata0); end
      a_write(8'd5, 16'hAA56, 2'b01);
      a_read(8'd5);
      tests++; if (a_rdata0 !== 16'h1256) begin fails++; $display("FAIL be_lo got %h exp 1256", a_rdata0); end
   endtask

   task automatic test_rdw();
      a_write(8'd9, 16'h1111, 2'b11);
      a_valid = 1'b1; a_we = 1'b1; a_addr = 8'd9; a_wdata = 16'h2222; a_be = 2'b11;
      b_valid = 1'b1; b_addr = 8'd9;
      step();
      a_valid = 1'b0; a_we = 1'b0; b_valid = 1'b0;
      tests++; if (b_rvalid0 !== 1'b1 || b_rdata0 !== 16'h1111) begin fails++; $display("FAIL rdw_old rvalid=%b data=%h exp 1 1111", b_rvalid0, b_rdata0); end
      tests++; if (b_rvalid1 !== 1'b1 || b_rdata1 !== 16'h2222) begin fails++; $display("FAIL rdw_new rvalid=%b data=%h exp 1 2222", b_rvalid1, b_rdata1); end
      b_valid = 1'b1; b_addr = 8'd9;
      step();
      b_valid = 1'b0;
      tests++; if (b_rdata0 !== 16'h2222 || b_rdata1 !== 16'h2222) begin fails++; $display("FAIL rdw_after got %h/%h exp 2222", b_rdata0, b_rdata1); end
      a_write(8'd9, 16'h00CC, 2'b01);
      tests++; if (b_rvalid0 !== 1'b0 || b_rdata0 !== 16'h2222) begin fails++; $display("FAIL b_hold rvalid=%b data=%h exp 0 2222", b_rvalid0, b_rdata0); end
      a_valid = 1'b1; a_we = 1'b1; a_addr = 8'd9; a_wdata = 16'h33DD; a_be = 2'b10;
      b_valid = 1'b1; b_addr = 8'd9;
      step();
      a_valid = 1'b0; a_we = 1'b0; b_valid = 1'b0;
      tests++; if (b_rdata0 !== 16'h22CC) begin fails++; $display("FAIL rdw_be_old got %h exp 22cc", b_rdata0); end
      tests++; if (b_rdata1 !== 16'h33CC) begin fails++; $display("FAIL rdw_be_new got %h exp 33cc", b_rdata1); end
      a_valid = 1'b1; a_addr = 8'd5; b_valid = 1'b1; b_addr = 8'd5;
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      tests++; if (a_rdata0 !== 16'h1256 || b_rdata0 !== 16'h1256 || b_rvalid0 !== 1'b1) begin fails++; $display("FAIL dual_read a=%h b=%h exp 1256 1256", a_rdata0, b_rdata0); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_d;
      int run;
      for (int i = 0; i < 16; i++) begin
         exp_d = 16'(i * 3);
         a_valid = 1'b1; a_we = 1'b1; a_addr = 8'(i); a_wdata = exp_d; a_be = 2'b11;
         step();
      end
      a_we = 1'b0;
      run = 0;
      for (int i = 0; i < 16; i++) begin
         a_addr = 8'(i);
         step();
         exp_d = 16'(i * 3);
         if (a_rvalid0 === 1'b1 && a_rdata0 === exp_d) run++;
         else $display("FAIL b2b_item%0d rvalid=%b data=%h exp 1 %h", i, a_rvalid0, a_rdata0, exp_d);
      end
      a_valid = 1'b0;
      tests++; if (run !== 16) begin fails++; $display("FAIL b2b_count got %0d exp 16", run); end
      step();
      tests++; if (a_rvalid0 !== 1'b0) begin fails++; $display("FAIL b2b_end rvalid=%b exp 0", a_rvalid0); end
   endtask

   task automatic test_oor();
      a_write(8'd210, 16'hABCD, 2'b11);
      tests++; if (a_err2 !== 1'b1 || a_rvalid2 !== 1'b0 || a_err0 !== 1'b0) begin fails++; $display("FAIL oor_wr err2=%b rvalid2=%b err0=%b exp 1 0 0", a_err2, a_rvalid2, a_err0); end
      step();
      tests++; if (a_err2 !== 1'b0) begin fails++; $display("FAIL oor_err_pulse got %b exp 0", a_err2); end
      a_read(8'd210);
      tests++; if (a_rvalid2 !== 1'b1 || a_rdata2 !== 16'h0000 || a_err2 !== 1'b1) begin fails++; $display("FAIL oor_rd rvalid=%b data=%h err=%b exp 1 0000 1", a_rvalid2, a_rdata2, a_err2); end
      tests++; if (a_rdata0 !== 16'hABCD || a_err0 !== 1'b0) begin fails++; $display("FAIL inrng_210 data=%h err=%b exp abcd 0", a_rdata0, a_err0); end
      b_valid = 1'b1; b_addr = 8'd210;
      step();
      b_valid = 1'b0;
      tests++; if (b_rvalid2 !== 1'b1 || b_rdata2 !== 16'h0000 || b_err2 !== 1'b1) begin fails++; $display("FAIL oor_b rvalid=%b data=%h err=%b exp 1 0000 1", b_rvalid2, b_rdata2, b_err2); end
      a_read(8'd10);
      tests++; if (a_rdata2 !== 16'h001E) begin fails++; $display("FAIL oor_no_alias got %h exp 001e", a_rdata2); end
   endtask

   task automatic test_clr();
      int n0, n2;
      a_valid = 1'b1; a_we = 1'b0; a_addr = 8'd3; clr = 1'b1;
      step();
      a_valid = 1'b0; clr = 1'b0;
      tests++; if (a_rvalid0 !== 1'b1 || a_rdata0 !== 16'h0009) begin fails++; $display("FAIL clr_read rvalid=%b data=%h exp 1 0009", a_rvalid0, a_rdata0); end
      tests++; if (busy0 !== 1'b1 || a_ready0 !== 1'b0) begin fails++; $display("FAIL clr_busy busy=%b ready=%b exp 1 0", busy0, a_ready0); end
      count_busy(n0, n2);
      tests++; if (n0 !== 256 || n2 !== 200) begin fails++; $display("FAIL clr_len got %0d/%0d exp 256/200", n0, n2); end
      a_read(8'd3);
      tests++; if (a_rvalid0 !== 1'b1 || a_rdata0 !== 16'h0000) begin fails++; $display("FAIL clr_zero rvalid=%b data=%h exp 1 0000", a_rvalid0, a_rdata0); end
   endtask

   task automatic test_reset_mid_clear();
      int n0, n2;
      a_write(8'd3, 16'h0777, 2'b11);
      a_valid = 1'b1; a_we = 1'b0; a_addr = 8'd3; rst_n = 1'b0;
      step();
      a_valid = 1'b0; rst_n = 1'b1;
      tests++; if (a_rvalid0 !== 1'b0 || a_rdata0 !== 16'h0000) begin fails++; $display("FAIL rst_drop rvalid=%b data=%h exp 0 0000", a_rvalid0, a_rdata0); end
      for (int i = 0; i < 100; i++) step();
      tests++; if (busy2 !== 1'b1) begin fails++; $display("FAIL mid_clear_busy got %b exp 1", busy2); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      count_busy(n0, n2);
      tests++; if (n2 !== 200 || n0 !== 256) begin fails++; $display("FAIL restart_len got %0d/%0d exp 200/256", n2, n0); end
      a_read(8'd3);
      tests++; if (a_rdata0 !== 16'h0000) begin fails++; $display("FAIL restart_zero got %h exp 0000", a_rdata0); end
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; a_valid = 1'b0; a_we = 1'b0; b_valid = 1'b0;
      a_addr = 8'd0; b_addr = 8'd0; a_wdata = 16'h0000; a_be = 2'b00;
      test_reset();
      test_byte_enable();
      test_rdw();
      test_back_to_back();
      test_oor();
      test_clr();
      test_reset_mid_clear();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
